// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite master: response codes and FSM state encoding.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWrReq  = 3'd1,
    StWrResp = 3'd2,
    StRdReq  = 3'd3,
    StRdData = 3'd4,
    StRsp    = 3'd5
  } state_e;

endpackage

// File: rtl/axi4_lite_master.sv
// AXI4-Lite master adaptor: single-outstanding command/response interface to AW/W/B/AR/R.
// Every output comes straight from a register.
// Optional watchdog: define AXI4_LITE_MASTER_TIMEOUT_EN to abort a stalled transfer with SLVERR
// after TIMEOUT_CYCLES cycles in any request/response wait state.
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [2:0]  PROT_VALUE     = 3'b000,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      aclk,
  input  logic                      areset,
  // User command
  input  logic                      cmd_valid_in,
  output logic                      cmd_ready_out,
  input  logic                      cmd_write_in,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr_in,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata_in,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb_in,
  // User response
  output logic                      rsp_valid_out,
  input  logic                      rsp_ready_in,
  output logic                      rsp_write_out,
  output logic [DATA_WIDTH-1:0]     rsp_rdata_out,
  output logic [1:0]                rsp_resp_out,
  // Write address channel
  output logic [ADDR_WIDTH-1:0]     awaddr_out,
  output logic [2:0]                awprot_out,
  output logic                      awvalid_out,
  input  logic                      awready_in,
  // Write data channel
  output logic [DATA_WIDTH-1:0]     wdata_out,
  output logic [DATA_WIDTH/8-1:0]   wstrb_out,
  output logic                      wvalid_out,
  input  logic                      wready_in,
  // Write response channel
  input  logic [1:0]                bresp_in,
  input  logic                      bvalid_in,
  output logic                      bready_out,
  // Read address channel
  output logic [ADDR_WIDTH-1:0]     araddr_out,
  output logic [2:0]                arprot_out,
  output logic                      arvalid_out,
  input  logic                      arready_in,
  // Read data channel
  input  logic [DATA_WIDTH-1:0]     rdata_in,
  input  logic [1:0]                rresp_in,
  input  logic                      rvalid_in,
  output logic                      rready_out
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  // Only 32-bit data is supported, and the watchdog needs a usable limit.
  if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("axi4_lite_master: unsupported DATA_WIDTH or TIMEOUT_CYCLES");
  end

  state_e                  state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_resp_q, rsp_resp_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          waiting;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;

    unique case (state_q)
      StIdle: begin
        // cmd_ready_q is low for one cycle after reset, so gate acceptance on it.
        cmd_ready_d = 1'b1;
        if (cmd_ready_q && cmd_valid_in) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr_in;
          if (cmd_write_in) begin
            wdata_d   = cmd_wdata_in;
            wstrb_d   = cmd_wstrb_in;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StWrReq;
          end else begin
            arvalid_d = 1'b1;
            state_d   = StRdReq;
          end
        end
      end
      StWrReq: begin
        // A low valid here means that channel has already handshaken.
        awvalid_d = awvalid_q && !awready_in;
        wvalid_d  = wvalid_q && !wready_in;
        if ((!awvalid_q || awready_in) && (!wvalid_q || wready_in)) begin
          bready_d = 1'b1;
          state_d  = StWrResp;
        end
      end
      StWrResp: begin
        if (bvalid_in && bready_q) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = bresp_in;
          state_d     = StRsp;
        end
      end
      StRdReq: begin
        if (arready_in) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdData;
        end
      end
      StRdData: begin
        if (rvalid_in && rready_q) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = rdata_in;
          rsp_resp_d  = rresp_in;
          state_d     = StRsp;
        end
      end
      StRsp: begin
        if (rsp_ready_in) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    // Counter restarts on every state entry; a real handshake on the limit cycle wins.
    waiting = (state_q == StWrReq) || (state_q == StWrResp) ||
              (state_q == StRdReq) || (state_q == StRdData);
    timer_d = '0;
    if (waiting && state_d == state_q) begin
      if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_write_d = (state_q == StWrReq) || (state_q == StWrResp);
        rsp_rdata_d = '0;
        rsp_resp_d  = RESP_SLVERR;
        state_d     = StRsp;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
`endif
  end

  // State and output registers; synchronous reset clears everything.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
    end
  end

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  // Watchdog counter register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`endif

  assign cmd_ready_out = cmd_ready_q;
  assign rsp_valid_out = rsp_valid_q;
  assign rsp_write_out = rsp_write_q;
  assign rsp_rdata_out = rsp_rdata_q;
  assign rsp_resp_out  = rsp_resp_q;
  assign awaddr_out    = addr_q;
  assign awprot_out    = PROT_VALUE;
  assign awvalid_out   = awvalid_q;
  assign wdata_out     = wdata_q;
  assign wstrb_out     = wstrb_q;
  assign wvalid_out    = wvalid_q;
  assign bready_out    = bready_q;
  assign araddr_out    = addr_q;
  assign arprot_out    = PROT_VALUE;
  assign arvalid_out   = arvalid_q;
  assign rready_out    = rready_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Scoreboard bench for axi4_lite_master: a behavioural AXI slave with per-transaction delays,
// a reference memory model, and a response monitor popping expected responses from a queue.
// Honours AXI4_LITE_MASTER_TIMEOUT_EN for the stalled-write scenario.
module tb_axi4_lite_master;

  localparam logic [2:0]  PROT = 3'b010;
  localparam int unsigned TMO  = 16;

  logic        aclk, areset;
  logic        cmd_valid_in, cmd_ready_out, cmd_write_in;
  logic [31:0] cmd_addr_in, cmd_wdata_in;
  logic [3:0]  cmd_wstrb_in;
  logic        rsp_valid_out, rsp_ready_in, rsp_write_out;
  logic [31:0] rsp_rdata_out;
  logic [1:0]  rsp_resp_out;
  logic [31:0] awaddr_out, wdata_out, araddr_out, rdata_in;
  logic [2:0]  awprot_out, arprot_out;
  logic        awvalid_out, awready_in, wvalid_out, wready_in;
  logic [3:0]  wstrb_out;
  logic [1:0]  bresp_in, rresp_in;
  logic        bvalid_in, bready_out, arvalid_out, arready_in, rvalid_in, rready_out;

  axi4_lite_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .PROT_VALUE(PROT), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out), .cmd_write_in(cmd_write_in),
    .cmd_addr_in(cmd_addr_in), .cmd_wdata_in(cmd_wdata_in), .cmd_wstrb_in(cmd_wstrb_in),
    .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in), .rsp_write_out(rsp_write_out),
    .rsp_rdata_out(rsp_rdata_out), .rsp_resp_out(rsp_resp_out),
    .awaddr_out(awaddr_out), .awprot_out(awprot_out), .awvalid_out(awvalid_out),
    .awready_in(awready_in),
    .wdata_out(wdata_out), .wstrb_out(wstrb_out), .wvalid_out(wvalid_out), .wready_in(wready_in),
    .bresp_in(bresp_in), .bvalid_in(bvalid_in), .bready_out(bready_out),
    .araddr_out(araddr_out), .arprot_out(arprot_out), .arvalid_out(arvalid_out),
    .arready_in(arready_in),
    .rdata_in(rdata_in), .rresp_in(rresp_in), .rvalid_in(rvalid_in), .rready_out(rready_out)
  );

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    int unsigned aw_dly, w_dly, ar_dly, b_dly, r_dly;
    bit          early;  // readies raised before the valids appear
    bit          hang;   // slave never returns B/R
  } txn_t;

  typedef struct {
    bit          write;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } rsp_t;

  txn_t        axi_q[$];
  rsp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  bit          hold_ready = 0;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- Behavioural AXI slave (samples and drives on negedge) ----------------
  txn_t        cur;
  bit          active, aw_seen, w_seen, ar_seen, wr_done;
  int unsigned aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic        awv_p, wv_p, arv_p, bry_p, rry_p;
  logic [31:0] awaddr_p, wdata_p, araddr_p;
  logic [3:0]  wstrb_p;
  logic [2:0]  awprot_p, arprot_p;

  always @(negedge aclk) begin
    if (areset) begin
      active = 0; awready_in = 0; wready_in = 0; arready_in = 0; bvalid_in = 0; rvalid_in = 0;
      bresp_in = 0; rresp_in = 0; rdata_in = 0;
      awv_p = 0; wv_p = 0; arv_p = 0; bry_p = 0; rry_p = 0;
    end else begin
      // Handshakes completed at the preceding posedge
      if (active) begin
        if (awready_in && awv_p && !aw_seen) begin
          aw_seen = 1;
          check("awaddr", awaddr_p, cur.addr);
          check("awprot", awprot_p, PROT);
        end
        if (wready_in && wv_p && !w_seen) begin
          w_seen = 1;
          check("wdata", wdata_p, cur.data);
          check("wstrb", wstrb_p, cur.strb);
        end
        if (aw_seen && w_seen && !wr_done) begin
          wr_done = 1;
          slv_mem[cur.addr] = merge(slv_mem.exists(cur.addr) ? slv_mem[cur.addr] : dflt(cur.addr),
                                    cur.data, cur.strb);
        end
        if (arready_in && arv_p && !ar_seen) begin
          ar_seen = 1;
          check("araddr", araddr_p, cur.addr);
          check("arprot", arprot_p, PROT);
        end
        if ((bvalid_in && bry_p) || (rvalid_in && rry_p)) begin
          active = 0; bvalid_in = 0; rvalid_in = 0;
        end
      end
      // Protocol rules: no valid dropped before handshake, payload stable meanwhile
      if (awv_p && !awready_in) check("aw held", {awvalid_out, awaddr_out}, {1'b1, awaddr_p});
      if (wv_p && !wready_in)
        check("w held", {wvalid_out, wdata_out, wstrb_out}, {1'b1, wdata_p, wstrb_p});
      if (arv_p && !arready_in) check("ar held", {arvalid_out, araddr_out}, {1'b1, araddr_p});
      if (bready_out) check("bready after aw and w", {1'b0, aw_seen && w_seen}, 2'b01);
      if (!active || !cur.write) check("spurious aw/w", {awvalid_out, wvalid_out}, 2'b00);
      if (!active || cur.write) check("spurious ar", arvalid_out, 1'b0);
      // Pick up the next transaction
      if (!active && axi_q.size() > 0) begin
        cur = axi_q.pop_front();
        active = 1; aw_seen = 0; w_seen = 0; ar_seen = 0; wr_done = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      end
      awready_in = 0; wready_in = 0; arready_in = 0;
      if (!bvalid_in) bresp_in = 2'($urandom_range(0, 3));
      if (!rvalid_in) begin rdata_in = $urandom; rresp_in = 2'($urandom_range(0, 3)); end
      if (active && cur.write) begin
        if (!aw_seen) begin
          if (cur.early || (awvalid_out && aw_cnt >= cur.aw_dly)) awready_in = 1;
          else if (awvalid_out) aw_cnt++;
        end
        if (!w_seen) begin
          if (cur.early || (wvalid_out && w_cnt >= cur.w_dly)) wready_in = 1;
          else if (wvalid_out) w_cnt++;
        end
        if (aw_seen && w_seen && !cur.hang && !bvalid_in) begin
          if (b_cnt >= cur.b_dly) begin bvalid_in = 1; bresp_in = cur.resp; end
          else b_cnt++;
        end
      end else if (active) begin
        if (!ar_seen) begin
          if (cur.early || (arvalid_out && ar_cnt >= cur.ar_dly)) arready_in = 1;
          else if (arvalid_out) ar_cnt++;
        end
        if (ar_seen && !cur.hang && !rvalid_in) begin
          if (r_cnt >= cur.r_dly) begin
            rvalid_in = 1; rresp_in = cur.resp;
            rdata_in = slv_mem.exists(cur.addr) ? slv_mem[cur.addr] : dflt(cur.addr);
          end else r_cnt++;
        end
      end
      awv_p = awvalid_out; wv_p = wvalid_out; arv_p = arvalid_out;
      bry_p = bready_out; rry_p = rready_out;
      awaddr_p = awaddr_out; awprot_p = awprot_out; wdata_p = wdata_out; wstrb_p = wstrb_out;
      araddr_p = araddr_out; arprot_p = arprot_out;
    end
  end

  // ---------------- Response monitor / scoreboard ----------------
  logic rv_p;
  rsp_t pay_p, e;

  always @(negedge aclk) begin
    if (areset) begin
      rv_p = 0; rsp_ready_in = 0;
    end else begin
      if (rv_p && rsp_ready_in) begin
        if (exp_q.size() == 0) begin
          check("unexpected response", rv_p, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_write", pay_p.write, e.write);
          check("rsp_rdata", pay_p.rdata, e.rdata);
          check("rsp_resp", pay_p.resp, e.resp);
        end
      end else if (rv_p) begin
        check("rsp held", {rsp_valid_out, rsp_write_out, rsp_rdata_out, rsp_resp_out},
              {1'b1, pay_p.write, pay_p.rdata, pay_p.resp});
      end
      if (rsp_valid_out) check("cmd_ready low while rsp", cmd_ready_out, 1'b0);
      rsp_ready_in = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
      rv_p = rsp_valid_out;
      pay_p.write = rsp_write_out; pay_p.rdata = rsp_rdata_out; pay_p.resp = rsp_resp_out;
    end
  end

  // ---------------- Stimulus ----------------
  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  function automatic txn_t mk(input bit wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [1:0] rs);
    txn_t t;
    t.write = wr; t.addr = a; t.data = d; t.strb = s; t.resp = rs;
    t.aw_dly = 0; t.w_dly = 0; t.ar_dly = 0; t.b_dly = 0; t.r_dly = 0;
    t.early = 0; t.hang = 0;
    return t;
  endfunction

  task automatic issue(input txn_t t);
    rsp_t x;
    int   n;
    n = 0;
    while (cmd_ready_out !== 1'b1 && n < 300) begin tick(); n++; end
    if (n >= 300) begin
      check("cmd_ready wait", cmd_ready_out, 1'b1);
      return;
    end
    x.write = t.write;
    x.resp  = t.resp;
    x.rdata = 0;
    if (t.write)
      ref_mem[t.addr] = merge(ref_mem.exists(t.addr) ? ref_mem[t.addr] : dflt(t.addr),
                              t.data, t.strb);
    else
      x.rdata = ref_mem.exists(t.addr) ? ref_mem[t.addr] : dflt(t.addr);
    if (!t.hang) exp_q.push_back(x);
    axi_q.push_back(t);
    cmd_valid_in = 1; cmd_write_in = t.write; cmd_addr_in = t.addr;
    cmd_wdata_in = t.data; cmd_wstrb_in = t.strb;
    tick();
    cmd_valid_in = 0; cmd_write_in = 1'($urandom); cmd_addr_in = $urandom;
    cmd_wdata_in = $urandom; cmd_wstrb_in = 4'($urandom);
    if (t.write) check("aw/w valid 1 cycle after accept", {awvalid_out, wvalid_out}, 2'b11);
    else         check("arvalid 1 cycle after accept", arvalid_out, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cmd_ready_out !== 1'b1) && n < 300) begin tick(); n++; end
    check("drain pending responses", exp_q.size(), 0);
  endtask

  task automatic wait_for(input string name, input int which);
    int n;
    logic s;
    n = 0;
    s = 0;
    while (n < 100) begin
      s = (which == 0) ? rsp_valid_out : rready_out;
      if (s) break;
      tick();
      n++;
    end
    check(name, s, 1'b1);
  endtask

  txn_t t;

  initial begin
    areset = 1; cmd_valid_in = 0; cmd_write_in = 0; cmd_addr_in = 0;
    cmd_wdata_in = 0; cmd_wstrb_in = 0;
    awready_in = 0; wready_in = 0; arready_in = 0; bvalid_in = 0; rvalid_in = 0;
    bresp_in = 0; rresp_in = 0; rdata_in = 0; rsp_ready_in = 0;
    repeat (3) tick();
    check("reset valids/readies",
          {cmd_ready_out, rsp_valid_out, awvalid_out, wvalid_out, bready_out, arvalid_out,
           rready_out}, 7'd0);
    check("reset addr/data", {awaddr_out, wdata_out}, 64'd0);
    check("reset strb/rsp", {wstrb_out, araddr_out, rsp_resp_out, rsp_write_out}, 39'd0);
    check("reset rdata", rsp_rdata_out, 32'd0);
    areset = 0;
    tick();
    check("cmd_ready after reset", cmd_ready_out, 1'b1);

    // Write with slave ready held high: valids last exactly one cycle
    t = mk(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00);
    t.early = 1;
    issue(t);
    tick();
    check("aw/w valid dropped after 1 cycle", {awvalid_out, wvalid_out}, 2'b00);
    drain();

    // Skewed write: awready late, wready immediate
    t = mk(1, 32'h0000_0014, 32'hCAFE_F00D, 4'b0101, 2'b01);
    t.aw_dly = 3;
    issue(t);
    tick();
    check("skew: wvalid low, awvalid high", {wvalid_out, awvalid_out}, 2'b01);
    check("skew: bready still low", bready_out, 1'b0);
    drain();

    // Read with arready after 2 cycles
    t = mk(1, 32'h0000_0020, 32'h1234_5678, 4'hF, 2'b00);
    issue(t);
    t = mk(0, 32'h0000_0020, 0, 0, 2'b00);
    t.ar_dly = 2;
    issue(t);
    tick();
    check("read: arvalid held while waiting", arvalid_out, 1'b1);
    drain();

    // DECERR pass-through under response backpressure
    hold_ready = 1;
    t = mk(0, 32'h0000_0024, 0, 0, 2'b11);
    t.r_dly = 1;
    issue(t);
    wait_for("rsp_valid arrives", 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp: rsp_valid held", rsp_valid_out, 1'b1);
      check("bp: cmd_ready low", cmd_ready_out, 1'b0);
    end
    hold_ready = 0;
    drain();

    // Reset while waiting for read data
    t = mk(0, 32'h0000_0028, 0, 0, 2'b00);
    t.hang = 1;
    issue(t);
    wait_for("rready before reset", 1);
    areset = 1;
    tick();
    check("mid-read reset clears handshakes",
          {cmd_ready_out, rsp_valid_out, awvalid_out, wvalid_out, bready_out, arvalid_out,
           rready_out}, 7'd0);
    areset = 0;
    tick();
    check("cmd_ready after mid-read reset", cmd_ready_out, 1'b1);
    check("no response after abort", rsp_valid_out, 1'b0);

    // Stalled write: B never arrives
    t = mk(1, 32'h0000_002C, 32'h0BAD_F00D, 4'hF, 2'b00);
    t.hang = 1;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    begin
      rsp_t x;
      x.write = 1; x.rdata = 0; x.resp = 2'b10;
      exp_q.push_back(x);
    end
    issue(t);
    drain();
    areset = 1;
    tick();
    areset = 0;
    tick();
`else
    issue(t);
    repeat (40) tick();
    check("stalled write: no response", rsp_valid_out, 1'b0);
    check("stalled write: bready still high", bready_out, 1'b1);
    areset = 1;
    tick();
    areset = 0;
    tick();
`endif

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      t = mk(1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 15) * 4), $urandom,
             4'($urandom_range(1, 15)), 2'($urandom_range(0, 3)));
      t.aw_dly = $urandom_range(0, 3); t.w_dly = $urandom_range(0, 3);
      t.ar_dly = $urandom_range(0, 3); t.b_dly = $urandom_range(0, 3);
      t.r_dly = $urandom_range(0, 3);
      t.early = ($urandom_range(0, 3) == 0);
      issue(t);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
